// File: rtl/seq_tx_gen.sv
// Serial pattern transmitter: sends PATTERN_W-bit frames, either a bounded number
// or continuously, with a configurable inter-frame gap and bit order.
module seq_tx_gen #(
    parameter int unsigned PATTERN_W  = 8,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_en_n,
    input  logic [PATTERN_W-1:0] i_pattern,
    input  logic [COUNT_W-1:0]   i_num_seq,
    output logic                 o_tx_bit,
    output logic                 o_tx_valid,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [COUNT_W-1:0]   o_seq_count
);

    localparam int unsigned BIT_W    = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PATTERN_W - 1);
    localparam logic [BIT_W-1:0] BIT_PRE  = BIT_W'(PATTERN_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state, w_state;
    logic [PATTERN_W-1:0]  r_shift, w_shift;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt;
    logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt;
    logic [COUNT_W-1:0]    r_num_seq, w_num_seq;
    logic [COUNT_W-1:0]    r_seq_count, w_seq_count;
    logic [COUNT_W-1:0]    w_count_inc;
    logic                  r_tx_bit, w_tx_bit;
    logic                  r_tx_valid, w_tx_valid;
    logic                  r_sof, w_sof;
    logic                  r_eof, w_eof;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  w_frame_start;

    // Bit that leaves the shifter first, and the shifter after one bit is taken.
    function automatic logic first_bit(input logic [PATTERN_W-1:0] v);
        return MSB_FIRST ? v[PATTERN_W-1] : v[0];
    endfunction

    function automatic logic [PATTERN_W-1:0] advance(input logic [PATTERN_W-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Next-state and next-output logic; a frame start is folded in at the end.
    always_comb begin
        w_state       = r_state;
        w_shift       = r_shift;
        w_bit_cnt     = r_bit_cnt;
        w_gap_cnt     = r_gap_cnt;
        w_num_seq     = r_num_seq;
        w_seq_count   = r_seq_count;
        w_count_inc   = r_seq_count + COUNT_W'(1);
        w_tx_bit      = 1'b0;
        w_tx_valid    = 1'b0;
        w_sof         = 1'b0;
        w_eof         = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        w_frame_start = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!i_tx_en_n) begin
                    w_num_seq     = i_num_seq;
                    w_seq_count   = '0;
                    w_frame_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt != BIT_LAST) begin
                    w_tx_bit   = first_bit(r_shift);
                    w_shift    = advance(r_shift);
                    w_bit_cnt  = r_bit_cnt + BIT_W'(1);
                    w_tx_valid = 1'b1;
                    w_busy     = 1'b1;
                    w_eof      = (r_bit_cnt == BIT_PRE);
                end else begin
                    // Last bit is on the wire: the frame counts as sent now.
                    w_seq_count = w_count_inc;
                    if ((r_num_seq != '0) && (w_count_inc == r_num_seq)) begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                    end else if (i_tx_en_n) begin
                        w_state = ST_IDLE;
                    end else if (GAP_CYCLES != 0) begin
                        w_state   = ST_GAP;
                        w_gap_cnt = '0;
                        w_busy    = 1'b1;
                    end else begin
                        w_frame_start = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (i_tx_en_n) begin
                    w_state = ST_IDLE;
                end else if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                    w_frame_start = 1'b1;
                end else begin
                    w_gap_cnt = r_gap_cnt + GAP_W'(1);
                    w_busy    = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_tx_en_n) begin
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_frame_start) begin
            w_state    = ST_SHIFT;
            w_tx_bit   = first_bit(i_pattern);
            w_shift    = advance(i_pattern);
            w_bit_cnt  = '0;
            w_tx_valid = 1'b1;
            w_sof      = 1'b1;
            w_busy     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_num_seq   <= '0;
            r_seq_count <= '0;
            r_tx_bit    <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_bit_cnt   <= w_bit_cnt;
            r_gap_cnt   <= w_gap_cnt;
            r_num_seq   <= w_num_seq;
            r_seq_count <= w_seq_count;
            r_tx_bit    <= w_tx_bit;
            r_tx_valid  <= w_tx_valid;
            r_sof       <= w_sof;
            r_eof       <= w_eof;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign o_tx_bit    = r_tx_bit;
    assign o_tx_valid  = r_tx_valid;
    assign o_sof       = r_sof;
    assign o_eof       = r_eof;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_seq_count = r_seq_count;

endmodule

// File: tb/tb_seq_tx_gen.sv
// Directed bench for seq_tx_gen: three instances cover default, LSB-first/no-gap
// and narrow-counter configurations.
module tb_seq_tx_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: defaults (8-bit pattern, 8-bit count, gap 2, MSB first)
    logic       en_a = 1'b1;
    logic [7:0] pat_a = 8'h00, num_a = 8'h00, cnt_a;
    logic       bit_a, val_a, sof_a, eof_a, busy_a, done_a;
    logic [5:0] obs_a;
    assign obs_a = {val_a, bit_a, sof_a, eof_a, busy_a, done_a};

    // Instance B: LSB first, back-to-back frames
    logic       en_b = 1'b1;
    logic [7:0] pat_b = 8'h00, num_b = 8'h00, cnt_b;
    logic       bit_b, val_b, sof_b, eof_b, busy_b, done_b;
    logic [5:0] obs_b;
    assign obs_b = {val_b, bit_b, sof_b, eof_b, busy_b, done_b};

    // Instance C: 2-bit frame counter
    logic       en_c = 1'b1;
    logic [7:0] pat_c = 8'h00;
    logic [1:0] num_c = 2'd0, cnt_c;
    logic       bit_c, val_c, sof_c, eof_c, busy_c, done_c;
    logic [5:0] obs_c;
    assign obs_c = {val_c, bit_c, sof_c, eof_c, busy_c, done_c};

    seq_tx_gen u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en_n(en_a), .i_pattern(pat_a), .i_num_seq(num_a),
        .o_tx_bit(bit_a), .o_tx_valid(val_a), .o_sof(sof_a), .o_eof(eof_a),
        .o_busy(busy_a), .o_done(done_a), .o_seq_count(cnt_a)
    );

    seq_tx_gen #(.PATTERN_W(8), .COUNT_W(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en_n(en_b), .i_pattern(pat_b), .i_num_seq(num_b),
        .o_tx_bit(bit_b), .o_tx_valid(val_b), .o_sof(sof_b), .o_eof(eof_b),
        .o_busy(busy_b), .o_done(done_b), .o_seq_count(cnt_b)
    );

    seq_tx_gen #(.PATTERN_W(8), .COUNT_W(2), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en_n(en_c), .i_pattern(pat_c), .i_num_seq(num_c),
        .o_tx_bit(bit_c), .o_tx_valid(val_c), .o_sof(sof_c), .o_eof(eof_c),
        .o_busy(busy_c), .o_done(done_c), .o_seq_count(cnt_c)
    );

    task automatic test_reset();
        #2;
        checks++;
        if ({obs_a, obs_b, obs_c} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0", {obs_a, obs_b, obs_c});
        end
        checks++;
        if ({cnt_a, cnt_b, cnt_c} !== 18'd0) begin
            errors++;
            $display("FAIL reset_counts got=%h/%h/%h required=0", cnt_a, cnt_b, cnt_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_a, busy_b, busy_c, val_a, val_b, val_c} !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle busy/valid=%b required=0",
                     {busy_a, busy_b, busy_c, val_a, val_b, val_c});
        end
    endtask

    // 3 frames of A5 with 2-cycle gaps, then a single done pulse and a quiet DONE state.
    task automatic test_bounded_run();
        logic [7:0] p = 8'hA5;
        logic [5:0] exp;
        pat_a = 8'hA5; num_a = 8'd3;
        en_a = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                exp = {1'b1, p[3'(7 - b)], (b == 0), (b == 7), 1'b1, 1'b0};
                checks++;
                if (obs_a !== exp) begin
                    errors++;
                    $display("FAIL bounded_bit f=%0d b=%0d got=%b required=%b", f, b, obs_a, exp);
                end
                checks++;
                if (cnt_a !== 8'(f)) begin
                    errors++;
                    $display("FAIL bounded_cnt f=%0d b=%0d got=%0d required=%0d", f, b, cnt_a, f);
                end
            end
            if (f < 2) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    checks++;
                    if (obs_a !== 6'b000010 || cnt_a !== 8'(f + 1)) begin
                        errors++;
                        $display("FAIL bounded_gap f=%0d g=%0d got=%b cnt=%0d required=000010 cnt=%0d",
                                 f, g, obs_a, cnt_a, f + 1);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if (obs_a !== 6'b000001 || cnt_a !== 8'd3) begin
            errors++;
            $display("FAIL bounded_done got=%b cnt=%0d required=000001 cnt=3", obs_a, cnt_a);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== 6'b000000 || cnt_a !== 8'd3) begin
                errors++;
                $display("FAIL bounded_hold k=%0d got=%b cnt=%0d required=000000 cnt=3", k, obs_a, cnt_a);
            end
        end
        en_a = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_a !== 6'b000000 || cnt_a !== 8'd3) begin
            errors++;
            $display("FAIL bounded_idle got=%b cnt=%0d required=000000 cnt=3", obs_a, cnt_a);
        end
    endtask

    // LSB first, no gap: 16 contiguous valid bits, done after the second frame.
    task automatic test_back_to_back();
        logic [7:0] p = 8'hA5;
        logic [5:0] exp;
        pat_b = 8'hA5; num_b = 8'd2;
        en_b = 1'b0;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            exp = {1'b1, p[3'(b % 8)], (b % 8 == 0), (b % 8 == 7), 1'b1, 1'b0};
            checks++;
            if (obs_b !== exp || cnt_b !== 8'(b / 8)) begin
                errors++;
                $display("FAIL b2b_bit b=%0d got=%b cnt=%0d required=%b cnt=%0d", b, obs_b, cnt_b, exp, b / 8);
            end
        end
        @(negedge clk);
        checks++;
        if (obs_b !== 6'b000001 || cnt_b !== 8'd2) begin
            errors++;
            $display("FAIL b2b_done got=%b cnt=%0d required=000001 cnt=2", obs_b, cnt_b);
        end
        en_b = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_b !== 6'b000000) begin
            errors++;
            $display("FAIL b2b_idle got=%b required=000000", obs_b);
        end
    endtask

    // Continuous run stopped mid-frame 2: frame completes, count 2, back to IDLE, no done.
    task automatic test_stop_midframe();
        logic [7:0] p = 8'hA5;
        logic [5:0] exp;
        pat_a = 8'hA5; num_a = 8'd0;
        en_a = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                exp = {1'b1, p[3'(7 - b)], (b == 0), (b == 7), 1'b1, 1'b0};
                checks++;
                if (obs_a !== exp) begin
                    errors++;
                    $display("FAIL stop_bit f=%0d b=%0d got=%b required=%b", f, b, obs_a, exp);
                end
                if (f == 1 && b == 3) en_a = 1'b1;
            end
            if (f == 0) repeat (2) @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== 6'b000000 || cnt_a !== 8'd2) begin
                errors++;
                $display("FAIL stop_idle k=%0d got=%b cnt=%0d required=000000 cnt=2", k, obs_a, cnt_a);
            end
        end
    endtask

    // Pattern change mid-frame 1 only takes effect at frame 2.
    task automatic test_pattern_change();
        logic [7:0] p;
        logic [5:0] exp;
        pat_a = 8'hA5; num_a = 8'd2;
        en_a = 1'b0;
        for (int f = 0; f < 2; f++) begin
            p = (f == 0) ? 8'hA5 : 8'h3C;
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                exp = {1'b1, p[3'(7 - b)], (b == 0), (b == 7), 1'b1, 1'b0};
                checks++;
                if (obs_a !== exp) begin
                    errors++;
                    $display("FAIL patchg_bit f=%0d b=%0d got=%b required=%b", f, b, obs_a, exp);
                end
                if (f == 0 && b == 4) pat_a = 8'h3C;
            end
            if (f == 0) repeat (2) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (obs_a !== 6'b000001 || cnt_a !== 8'd2) begin
            errors++;
            $display("FAIL patchg_done got=%b cnt=%0d required=000001 cnt=2", obs_a, cnt_a);
        end
        en_a = 1'b1;
        @(negedge clk);
    endtask

    // Async reset at bit 5 of frame 2, released with enable still low.
    task automatic test_async_reset();
        logic [7:0] p = 8'hA5;
        logic [5:0] exp;
        bit         stopped = 1'b0;
        pat_a = 8'hA5; num_a = 8'd0;
        en_a = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (obs_a !== 6'b110010 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL arst_pre got=%b cnt=%0d required=110010 cnt=1", obs_a, cnt_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== 6'b000000 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL arst_drop got=%b cnt=%0d required=000000 cnt=0", obs_a, cnt_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            exp = {1'b1, p[3'(7 - b)], (b == 0), (b == 7), 1'b1, 1'b0};
            checks++;
            if (obs_a !== exp || cnt_a !== 8'd0) begin
                errors++;
                $display("FAIL arst_frame b=%0d got=%b cnt=%0d required=%b cnt=0", b, obs_a, cnt_a, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (obs_a !== 6'b000010 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL arst_gap got=%b cnt=%0d required=000010 cnt=1", obs_a, cnt_a);
        end
        en_a = 1'b1;
        for (int k = 0; k < 20 && !stopped; k++) begin
            @(negedge clk);
            if (!busy_a) stopped = 1'b1;
        end
        checks++;
        if (!stopped) begin
            errors++;
            $display("FAIL arst_stop busy=%b required=0 within 20 cycles", busy_a);
        end
    endtask

    // 2-bit counter in continuous mode wraps silently: 1,2,3,0,1 and never done.
    task automatic test_count_wrap();
        logic [1:0] cseq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        pat_c = 8'hA5; num_c = 2'd0;
        en_c = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                if (b == 0) begin
                    checks++;
                    if (sof_c !== 1'b1 || val_c !== 1'b1) begin
                        errors++;
                        $display("FAIL wrap_sof f=%0d sof=%b valid=%b required=1/1", f, sof_c, val_c);
                    end
                    if (f == 4) en_c = 1'b1;
                end
            end
            @(negedge clk);
            checks++;
            if (cnt_c !== cseq[f] || done_c !== 1'b0 || busy_c !== (f < 4)) begin
                errors++;
                $display("FAIL wrap_cnt f=%0d cnt=%0d done=%b busy=%b required cnt=%0d done=0 busy=%b",
                         f, cnt_c, done_c, busy_c, cseq[f], (f < 4));
            end
            if (f < 4) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_bounded_run();
        test_back_to_back();
        test_stop_midframe();
        test_pattern_change();
        test_async_reset();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
